hazard_scoreboard: RTL and testbench

- Parametrised successor to the core's hazard-detect and forwarding logic.
- Owns a 3-slot in-flight scoreboard (EXE, MEM, WB) and computes freeze, flush gating and per-source forwarding selects.
- Supports N source operands and a variable-latency data memory through a mem_ready stall.
- Sits beside the ID/EXE pipeline registers; drives IF/ID freeze and the EXE operand muxes.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_src_cmp.sv | 30 +++
 rtl/hazard_scoreboard.sv | 163 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: forwarding select codes
// and the in-flight slot record carried by the E, M and W scoreboard entries.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 4;
    // Slot dest field is sized for the widest supported register index.
    localparam int unsigned REG_AW_MAX = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] dest;
        logic                  wb_en;
        logic                  mem_r;
        logic                  mem_w;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_src_cmp.sv
// Compares one ID source index against the E, M and W scoreboard slots.
module hazard_src_cmp
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  slot_t             slot_e,
    input  slot_t             slot_m,
    input  slot_t             slot_w,
    output logic              e_hit,
    output logic              e_load,
    output logic              m_hit,
    output logic              w_hit
);

    logic [REG_AW_MAX-1:0] src_x;
    logic                  unused_bits;

    always_comb begin
        src_x  = REG_AW_MAX'(src);
        e_hit  = slot_e.valid & slot_e.wb_en & (slot_e.dest == src_x);
        e_load = e_hit & slot_e.mem_r;
        m_hit  = slot_m.valid & slot_m.wb_en & (slot_m.dest == src_x);
        w_hit  = slot_w.valid & slot_w.wb_en & (slot_w.dest == src_x);
    end

    assign unused_bits = ^{slot_e.mem_w, slot_m.mem_r, slot_m.mem_w, slot_w.mem_r, slot_w.mem_w};

endmodule

// File: rtl/hazard_scoreboard.sv
// Three-slot (E/M/W) in-flight scoreboard producing freeze, flush and forwarding selects.
// Optional saturating performance counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter int unsigned NUM_SRC   = 2,
    parameter bit          WB_HAZARD = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fwd_en,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dest,
    input  logic                      id_wb_en,
    input  logic                      id_mem_r,
    input  logic                      id_mem_w,
    input  logic                      br_taken,
    input  logic                      mem_ready,
    output logic                      freeze,
    output logic                      mem_stall,
    output logic                      flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]               perf_freeze,
    output logic [31:0]               perf_mstall,
    output logic [31:0]               perf_flush,
`endif
    output logic [2*NUM_SRC-1:0]      fwd_sel
);

    slot_t                     e_q, e_d, m_q, m_d, w_q, w_d;
    logic [NUM_SRC*REG_AW-1:0] e_src_q, e_src_d;
    logic [NUM_SRC-1:0]        e_used_q, e_used_d;
    logic [NUM_SRC-1:0]        src_hz;
    logic                      hz_frz;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic e_hit, e_load, m_hit, w_hit;

        hazard_src_cmp #(
            .REG_AW (REG_AW)
        ) u_cmp (
            .src    (id_src[i*REG_AW +: REG_AW]),
            .slot_e (e_q),
            .slot_m (m_q),
            .slot_w (w_q),
            .e_hit  (e_hit),
            .e_load (e_load),
            .m_hit  (m_hit),
            .w_hit  (w_hit)
        );

        assign src_hz[i] = id_valid & id_src_used[i] &
                           ((e_hit & (~fwd_en | e_load)) |
                            (m_hit & ~fwd_en) |
                            (w_hit & ~fwd_en & WB_HAZARD));
    end

    always_comb begin
        mem_stall = m_q.valid & (m_q.mem_r | m_q.mem_w) & ~mem_ready;
        flush     = br_taken & ~mem_stall;
        hz_frz    = (|src_hz) & ~flush;
        freeze    = mem_stall | hz_frz;
    end

    always_comb begin
        e_d      = e_q;
        m_d      = m_q;
        w_d      = w_q;
        e_src_d  = e_src_q;
        e_used_d = e_used_q;
        if (!mem_stall) begin
            w_d = m_q;
            m_d = e_q;
            if (flush | hz_frz | ~id_valid) begin
                e_d      = SLOT_EMPTY;
                e_src_d  = '0;
                e_used_d = '0;
            end else begin
                e_d.valid = 1'b1;
                e_d.dest  = REG_AW_MAX'(id_dest);
                e_d.wb_en = id_wb_en;
                e_d.mem_r = id_mem_r;
                e_d.mem_w = id_mem_w;
                e_src_d   = id_src;
                e_used_d  = id_src_used;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q      <= SLOT_EMPTY;
            m_q      <= SLOT_EMPTY;
            w_q      <= SLOT_EMPTY;
            e_src_q  <= '0;
            e_used_q <= '0;
        end else begin
            e_q      <= e_d;
            m_q      <= m_d;
            w_q      <= w_d;
            e_src_q  <= e_src_d;
            e_used_q <= e_used_d;
        end
    end

    logic [REG_AW_MAX-1:0] e_src_x;
    logic                  m_fwd, w_fwd;

    // A load in M is excluded: load-use stalling ensures its consumer sees it in W.
    always_comb begin
        fwd_sel = '0;
        e_src_x = '0;
        m_fwd   = 1'b0;
        w_fwd   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            e_src_x = REG_AW_MAX'(e_src_q[i*REG_AW +: REG_AW]);
            m_fwd   = m_q.valid & m_q.wb_en & ~m_q.mem_r & (m_q.dest == e_src_x);
            w_fwd   = w_q.valid & w_q.wb_en & (w_q.dest == e_src_x);
            if (fwd_en & e_q.valid & e_used_q[i]) begin
                if (m_fwd) begin
                    fwd_sel[2*i +: 2] = FWD_MEM;
                end else if (w_fwd) begin
                    fwd_sel[2*i +: 2] = FWD_WB;
                end
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] pf_freeze_q, pf_freeze_d;
    logic [31:0] pf_mstall_q, pf_mstall_d;
    logic [31:0] pf_flush_q, pf_flush_d;

    always_comb begin
        pf_freeze_d = pf_freeze_q;
        pf_mstall_d = pf_mstall_q;
        pf_flush_d  = pf_flush_q;
        if (hz_frz && !mem_stall && pf_freeze_q != 32'hFFFF_FFFF) pf_freeze_d = pf_freeze_q + 32'd1;
        if (mem_stall && pf_mstall_q != 32'hFFFF_FFFF) pf_mstall_d = pf_mstall_q + 32'd1;
        if (flush && pf_flush_q != 32'hFFFF_FFFF) pf_flush_d = pf_flush_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pf_freeze_q <= '0;
            pf_mstall_q <= '0;
            pf_flush_q  <= '0;
        end else begin
            pf_freeze_q <= pf_freeze_d;
            pf_mstall_q <= pf_mstall_d;
            pf_flush_q  <= pf_flush_d;
        end
    end

    assign perf_freeze = pf_freeze_q;
    assign perf_mstall = pf_mstall_q;
    assign perf_flush  = pf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, no-forward stalls,
// branch flush override, memory stall with deferred flush and asynchronous reset.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       fwd_en;
    logic       id_valid;
    logic [7:0] id_src;
    logic [1:0] id_src_used;
    logic [3:0] id_dest;
    logic       id_wb_en;
    logic       id_mem_r;
    logic       id_mem_w;
    logic       br_taken;
    logic       mem_ready;
    logic       freeze;
    logic       mem_stall;
    logic       flush;
    logic [3:0] fwd_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_freeze, perf_mstall, perf_flush;
`endif

    int vecs = 0;
    int errs = 0;

    hazard_scoreboard #(
        .REG_AW    (4),
        .NUM_SRC   (2),
        .WB_HAZARD (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fwd_en      (fwd_en),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_dest     (id_dest),
        .id_wb_en    (id_wb_en),
        .id_mem_r    (id_mem_r),
        .id_mem_w    (id_mem_w),
        .br_taken    (br_taken),
        .mem_ready   (mem_ready),
        .freeze      (freeze),
        .mem_stall   (mem_stall),
        .flush       (flush),
`ifdef HAZARD_PERF_CNT_EN
        .perf_freeze (perf_freeze),
        .perf_mstall (perf_mstall),
        .perf_flush  (perf_flush),
`endif
        .fwd_sel     (fwd_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] s0, input logic u0, input logic [3:0] s1,
                         input logic u1, input logic [3:0] d, input logic mr);
        id_valid    = 1'b1;
        id_src      = {s1, s0};
        id_src_used = {u1, u0};
        id_dest     = d;
        id_wb_en    = 1'b1;
        id_mem_r    = mr;
        id_mem_w    = 1'b0;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_src_used = 2'b00;
        id_mem_r    = 1'b0;
    endtask

    task automatic clear_pipe();
        idle();
        br_taken  = 1'b0;
        mem_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fwd_en = 1'b1;
        br_taken = 1'b0;
        mem_ready = 1'b0;
        issue(4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b0);
        #2;
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL rst_freeze: got %b want 0", freeze); end
        vecs++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL rst_mstall: got %b want 0", mem_stall); end
        vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL rst_flush: got %b want 0", flush); end
        vecs++; if (fwd_sel !== 4'b0000) begin errs++; $display("FAIL rst_fwd: got %b want 0000", fwd_sel); end
        @(negedge clk);
        rst = 1'b1;
        clear_pipe();
    endtask

    // ADD r1 then SUB r2,r1,r3: no stall, ALU result forwarded from M.
    task automatic test_forward_alu();
        fwd_en = 1'b1;
        issue(4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b0);
        @(negedge clk);
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL alu_frz0: got %b want 0", freeze); end
        tick();
        issue(4'd1, 1'b1, 4'd3, 1'b1, 4'd2, 1'b0);
        @(negedge clk);
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL alu_frz1: got %b want 0", freeze); end
        vecs++; if (fwd_sel !== 4'b0000) begin errs++; $display("FAIL alu_fwd0: got %b want 0000", fwd_sel); end
        tick();
        idle();
        @(negedge clk);
        vecs++; if (fwd_sel !== 4'b0001) begin errs++; $display("FAIL alu_fwd1: got %b want 0001", fwd_sel); end
        tick();
        @(negedge clk);
        vecs++; if (fwd_sel !== 4'b0000) begin errs++; $display("FAIL alu_fwd2: got %b want 0000", fwd_sel); end
        clear_pipe();
    endtask

    // LDR r4 then ADD r5,r4,r4: one bubble, then both sources from WB.
    task automatic test_load_use();
        fwd_en = 1'b1;
        issue(4'd6, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1);
        tick();
        issue(4'd4, 1'b1, 4'd4, 1'b1, 4'd5, 1'b0);
        @(negedge clk);
        vecs++; if (freeze !== 1'b1) begin errs++; $display("FAIL lu_frz1: got %b want 1", freeze); end
        vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL lu_flush: got %b want 0", flush); end
        tick();
        @(negedge clk);
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL lu_frz2: got %b want 0", freeze); end
        tick();
        idle();
        @(negedge clk);
        vecs++; if (fwd_sel !== 4'b1010) begin errs++; $display("FAIL lu_fwd: got %b want 1010", fwd_sel); end
        clear_pipe();
    endtask

    // Forwarding off: MOV r2 then user of r2 stalls for E and M matches only.
    task automatic test_no_forward();
        fwd_en = 1'b0;
        issue(4'd7, 1'b1, 4'd0, 1'b0, 4'd2, 1'b0);
        tick();
        issue(4'd2, 1'b1, 4'd1, 1'b1, 4'd3, 1'b0);
        @(negedge clk);
        vecs++; if (freeze !== 1'b1) begin errs++; $display("FAIL nf_frz_e: got %b want 1", freeze); end
        tick();
        @(negedge clk);
        vecs++; if (freeze !== 1'b1) begin errs++; $display("FAIL nf_frz_m: got %b want 1", freeze); end
        tick();
        @(negedge clk);
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL nf_frz_w: got %b want 0", freeze); end
        vecs++; if (fwd_sel !== 4'b0000) begin errs++; $display("FAIL nf_fwd0: got %b want 0000", fwd_sel); end
        tick();
        idle();
        @(negedge clk);
        vecs++; if (fwd_sel !== 4'b0000) begin errs++; $display("FAIL nf_fwd1: got %b want 0000", fwd_sel); end
        fwd_en = 1'b1;
        clear_pipe();
    endtask

    // Load-use hazard coinciding with a taken branch: flush wins, E bubbled.
    task automatic test_flush_override();
        fwd_en = 1'b1;
        issue(4'd6, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1);
        tick();
        issue(4'd4, 1'b1, 4'd4, 1'b1, 4'd5, 1'b0);
        br_taken = 1'b1;
        @(negedge clk);
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL fl_frz: got %b want 0", freeze); end
        vecs++; if (flush !== 1'b1) begin errs++; $display("FAIL fl_flush: got %b want 1", flush); end
        tick();
        br_taken = 1'b0;
        fwd_en = 1'b0;
        issue(4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b0);
        @(negedge clk);
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL fl_bubble: got %b want 0", freeze); end
        fwd_en = 1'b1;
        clear_pipe();
    endtask

    // MOV r9, LDR r4, ADD r8,r9,r10 -> ADD in E forwards r9 from W while LDR stalls in M.
    task automatic fill_stall_pipe();
        fwd_en = 1'b1;
        issue(4'd1, 1'b1, 4'd0, 1'b0, 4'd9, 1'b0);
        tick();
        issue(4'd2, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1);
        tick();
        issue(4'd9, 1'b1, 4'd10, 1'b1, 4'd8, 1'b0);
        tick();
        idle();
        mem_ready = 1'b0;
    endtask

    task automatic test_mem_stall_branch();
        fill_stall_pipe();
        br_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vecs++; if (mem_stall !== 1'b1) begin errs++; $display("FAIL ms_stall[%0d]: got %b want 1", k, mem_stall); end
            vecs++; if (freeze !== 1'b1) begin errs++; $display("FAIL ms_frz[%0d]: got %b want 1", k, freeze); end
            vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL ms_flush[%0d]: got %b want 0", k, flush); end
            vecs++; if (fwd_sel !== 4'b0010) begin errs++; $display("FAIL ms_fwd[%0d]: got %b want 0010", k, fwd_sel); end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        vecs++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL ms_rel_stall: got %b want 0", mem_stall); end
        vecs++; if (flush !== 1'b1) begin errs++; $display("FAIL ms_rel_flush: got %b want 1", flush); end
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL ms_rel_frz: got %b want 0", freeze); end
        tick();
        br_taken = 1'b0;
        clear_pipe();
    endtask

    task automatic test_reset_mid_stall();
        fill_stall_pipe();
        @(negedge clk);
        vecs++; if (mem_stall !== 1'b1) begin errs++; $display("FAIL rs_pre_stall: got %b want 1", mem_stall); end
        #1 rst = 1'b0;
        #1;
        vecs++; if (mem_stall !== 1'b0) begin errs++; $display("FAIL rs_stall: got %b want 0", mem_stall); end
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL rs_frz: got %b want 0", freeze); end
        vecs++; if (flush !== 1'b0) begin errs++; $display("FAIL rs_flush: got %b want 0", flush); end
        vecs++; if (fwd_sel !== 4'b0000) begin errs++; $display("FAIL rs_fwd: got %b want 0000", fwd_sel); end
        tick();
        rst = 1'b1;
        mem_ready = 1'b1;
        fwd_en = 1'b0;
        // Sources name pre-reset destinations so stale slots would show as a freeze.
        issue(4'd4, 1'b1, 4'd9, 1'b1, 4'd1, 1'b0);
        @(negedge clk);
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL rs_i1: got %b want 0", freeze); end
        tick();
        issue(4'd8, 1'b1, 4'd4, 1'b1, 4'd2, 1'b0);
        @(negedge clk);
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL rs_i2: got %b want 0", freeze); end
        tick();
        issue(4'd9, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0);
        @(negedge clk);
        vecs++; if (freeze !== 1'b0) begin errs++; $display("FAIL rs_i3: got %b want 0", freeze); end
        tick();
        fwd_en = 1'b1;
        clear_pipe();
    endtask

    initial begin
        test_reset();
        test_forward_alu();
        test_load_use();
        test_no_forward();
        test_flush_override();
        test_mem_stall_branch();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
